sram_nbank_ctrl: RTL and testbench

Parametrised multi-bank SRAM front end that sits between a single-port requester and `NUM_BANKS` identical external bank macros. It decodes bank-select bits, registers each request before driving it to the target bank, applies a write mask, and returns read data with a fixed, flagged latency. Each bank has an idle-timeout power FSM: the block puts unused banks to sleep and wakes them on demand, stalling the requester through `ready0`.

---
 rtl/sram_nbank_pkg.sv | 21 ++
 rtl/sram_bank_pm.sv | 94 +++++++++
 rtl/sram_nbank_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_nbank_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_nbank_pkg.sv
// Shared types and width helpers for the multi-bank SRAM front end.
package sram_nbank_pkg;

  // Per-bank power state
  typedef enum logic [1:0] {
    AWAKE = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } bank_pwr_e;

  // Bits needed to select one of n banks (at least 1)
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed for a counter that holds 0..max_val (at least 1)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_bank_pm.sv
// Per-bank power manager: idle timeout into SLEEP, timed wake-up back to AWAKE.
module sram_bank_pm
  import sram_nbank_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,      // a request currently targets this bank
  input  logic i_access,   // accept or S1 activity on this bank this cycle
  output logic o_awake_c,  // bank may be accessed this cycle
  output logic o_sleep     // bank is in its low-power state
);

  localparam int unsigned IW        = cnt_width(IDLE_CYCLES);
  localparam int unsigned WW        = cnt_width(WAKE_CYCLES);
  localparam int unsigned IDLE_LAST = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;

  bank_pwr_e       r_state;
  bank_pwr_e       w_state_nxt;
  logic [IW-1:0]   r_idle_cnt;
  logic [IW-1:0]   w_idle_nxt;
  logic [WW-1:0]   r_wake_cnt;
  logic [WW-1:0]   w_wake_nxt;
  logic            r_sleep;
  logic            w_sleep_nxt;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= AWAKE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_sleep    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_sleep    <= w_sleep_nxt;
    end
  end

  // Next state: an access always beats a coinciding idle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = r_wake_cnt;
    case (r_state)
      AWAKE: begin
        if (i_access) begin
          w_idle_nxt = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (r_idle_cnt == IW'(IDLE_LAST)) begin
            w_state_nxt = SLEEP;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + IW'(1);
          end
        end
      end
      SLEEP: begin
        if (i_req) begin
          w_state_nxt = WAKE;
          w_wake_nxt  = WW'(WAKE_CYCLES);
        end
      end
      WAKE: begin
        // Leaving on the step that reaches zero gives WAKE_CYCLES+1 stall cycles
        if (r_wake_cnt <= WW'(1)) begin
          w_state_nxt = AWAKE;
          w_wake_nxt  = '0;
          w_idle_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake_cnt - WW'(1);
        end
      end
      default: begin
        w_state_nxt = AWAKE;
        w_idle_nxt  = '0;
        w_wake_nxt  = '0;
      end
    endcase
  end

  // Outputs derived from current and next state
  always_comb begin
    o_awake_c   = (r_state == AWAKE);
    w_sleep_nxt = (w_state_nxt == SLEEP);
  end

  assign o_sleep = r_sleep;

endmodule

// File: rtl/sram_nbank_ctrl.sv
// Multi-bank SRAM front end: registered bank request, read return pipeline, per-bank power control.
module sram_nbank_ctrl
  import sram_nbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned NUM_WMASK   = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned OUT_REG     = 1
) (
  input  logic                                   clk0,
  input  logic                                   rst0,
  input  logic                                   csb0,
  input  logic                                   web0,
  input  logic [ADDR_WIDTH-1:0]                  addr0,
  input  logic [DATA_WIDTH-1:0]                  din0,
  input  logic [NUM_WMASK-1:0]                   wmask0,
  output logic                                   ready0,
  output logic [DATA_WIDTH-1:0]                  dout0,
  output logic                                   dvalid0,
  output logic [NUM_BANKS-1:0]                   bank_csb,
  output logic [NUM_BANKS-1:0]                   bank_web,
  output logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0] bank_addr,
  output logic [DATA_WIDTH-1:0]                  bank_din,
  output logic [NUM_WMASK-1:0]                   bank_wmask,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]        bank_dout,
  output logic [NUM_BANKS-1:0]                   bank_sleep
);

  localparam int unsigned BANK_SEL = sel_width(NUM_BANKS);
  localparam int unsigned BA_W     = ADDR_WIDTH - BANK_SEL;

  logic [BANK_SEL-1:0]   w_tgt_bank;
  logic [NUM_BANKS-1:0]  w_awake;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic [NUM_BANKS-1:0]  r_bank_csb;
  logic [NUM_BANKS-1:0]  r_bank_web;
  logic [BA_W-1:0]       r_bank_addr;
  logic [DATA_WIDTH-1:0] r_bank_din;
  logic [NUM_WMASK-1:0]  r_bank_wmask;
  logic [BANK_SEL-1:0]   r_s1_bank;
  logic                  r_s1_rd;
  logic [BANK_SEL-1:0]   r_s2_bank;
  logic                  r_s2_rd;

  assign w_tgt_bank = addr0[ADDR_WIDTH-1 -: BANK_SEL];
  assign ready0     = !rst0 && w_awake[w_tgt_bank];
  assign w_accept   = !csb0 && ready0;

  // One power manager per bank; S1 activity counts as an access
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic w_hit;
    assign w_hit = !csb0 && (w_tgt_bank == BANK_SEL'(g));

    sram_bank_pm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_pm (
      .clk       (clk0),
      .rst       (rst0),
      .i_req     (w_hit),
      .i_access  ((w_accept && w_hit) || !r_bank_csb[g]),
      .o_awake_c (w_awake[g]),
      .o_sleep   (bank_sleep[g])
    );
  end

  // S1 request register: drives the target bank for exactly one cycle
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_bank_csb   <= '1;
      r_bank_web   <= '1;
      r_bank_addr  <= '0;
      r_bank_din   <= '0;
      r_bank_wmask <= '0;
      r_s1_bank    <= '0;
      r_s1_rd      <= 1'b0;
    end else begin
      r_bank_csb <= '1;
      r_bank_web <= '1;
      r_s1_rd    <= 1'b0;
      if (w_accept) begin
        r_bank_csb[w_tgt_bank] <= 1'b0;
        r_bank_web[w_tgt_bank] <= web0;
        r_bank_addr            <= addr0[BA_W-1:0];
        r_bank_din             <= din0;
        r_bank_wmask           <= wmask0;
        r_s1_bank              <= w_tgt_bank;
        r_s1_rd                <= web0;
      end
    end
  end

  assign bank_csb   = r_bank_csb;
  assign bank_web   = r_bank_web;
  assign bank_addr  = r_bank_addr;
  assign bank_din   = r_bank_din;
  assign bank_wmask = r_bank_wmask;

  // S2: carry read flag and bank select to the cycle the bank presents data
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_s2_bank <= '0;
      r_s2_rd   <= 1'b0;
    end else begin
      r_s2_bank <= r_s1_bank;
      r_s2_rd   <= r_s1_rd;
    end
  end

  assign w_rdata = bank_dout[r_s2_bank*DATA_WIDTH +: DATA_WIDTH];

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dvalid;

    // Registered read return, one cycle after the bank presents data
    always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
        r_dout   <= '0;
        r_dvalid <= 1'b0;
      end else begin
        r_dvalid <= r_s2_rd;
        if (r_s2_rd) begin
          r_dout <= w_rdata;
        end
      end
    end

    assign dout0   = r_dout;
    assign dvalid0 = r_dvalid;
  end else begin : g_out_comb
    assign dout0   = r_s2_rd ? w_rdata : '0;
    assign dvalid0 = r_s2_rd;
  end

endmodule

// File: tb/tb_sram_nbank_ctrl.sv
// Directed bench: registered-output instance with power management, plus a
// combinational-output instance with sleep disabled fed the same accepted requests.
module tb_sram_nbank_ctrl;

  logic        clk = 1'b0;
  logic        rst0;
  logic        csb0, web0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [3:0]  wmask0;
  logic [31:0] cur_exp;

  logic        a_ready, a_dv, b_ready, b_dv, b_csb;
  logic [31:0] a_dout, b_dout, a_bdin, b_bdin;
  logic [3:0]  a_bcsb, a_bweb, a_bwm, a_bsleep, b_bcsb, b_bweb, b_bwm, b_bsleep;
  logic [7:0]  a_baddr, b_baddr;
  wire  [127:0] a_bdout, b_bdout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  // Instance B only sees requests that instance A accepts
  assign b_csb = !(!csb0 && a_ready);

  sram_nbank_ctrl #(.OUT_REG(1), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) u_dut (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .wmask0(wmask0), .ready0(a_ready), .dout0(a_dout),
    .dvalid0(a_dv), .bank_csb(a_bcsb), .bank_web(a_bweb), .bank_addr(a_baddr),
    .bank_din(a_bdin), .bank_wmask(a_bwm), .bank_dout(a_bdout),
    .bank_sleep(a_bsleep)
  );

  sram_nbank_ctrl #(.OUT_REG(0), .IDLE_CYCLES(0), .WAKE_CYCLES(2)) u_dut_b (
    .clk0(clk), .rst0(rst0), .csb0(b_csb), .web0(web0), .addr0(addr0),
    .din0(din0), .wmask0(wmask0), .ready0(b_ready), .dout0(b_dout),
    .dvalid0(b_dv), .bank_csb(b_bcsb), .bank_web(b_bweb), .bank_addr(b_baddr),
    .bank_din(b_bdin), .bank_wmask(b_bwm), .bank_dout(b_bdout),
    .bank_sleep(b_bsleep)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // Bank macro models: capture on the edge where csb is low
  for (genvar gb = 0; gb < 4; gb++) begin : g_bm
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a, rd_b;
    always @(posedge clk) begin
      if (!a_bcsb[gb]) begin
        if (!a_bweb[gb]) mem_a[a_baddr] <= merge(mem_a[a_baddr], a_bdin, a_bwm);
        else             rd_a <= mem_a[a_baddr];
      end
      if (!b_bcsb[gb]) begin
        if (!b_bweb[gb]) mem_b[b_baddr] <= merge(mem_b[b_baddr], b_bdin, b_bwm);
        else             rd_b <= mem_b[b_baddr];
      end
    end
    assign a_bdout[gb*32 +: 32] = rd_a;
    assign b_bdout[gb*32 +: 32] = rd_b;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept monitor: queue expected read data with its return cycle
  always @(posedge clk) begin
    if (!rst0 && !csb0 && a_ready && web0) begin
      qa.push_back('{d: cur_exp, c: cyc + 3});
      qb.push_back('{d: cur_exp, c: cyc + 2});
    end
    cyc <= cyc + 1;
  end

  // Return monitor: every dvalid must match the oldest outstanding read
  always @(negedge clk) begin
    if (!rst0) begin
      if (a_dv) begin
        if (qa.size() == 0) check("a_dv_spurious", 64'(a_dv), 64'(0));
        else begin
          check("a_rd_data", 64'(a_dout), 64'(qa[0].d));
          check("a_rd_cycle", 64'(cyc), 64'(qa[0].c));
          void'(qa.pop_front());
        end
      end
      if (b_dv) begin
        if (qb.size() == 0) check("b_dv_spurious", 64'(b_dv), 64'(0));
        else begin
          check("b_rd_data", 64'(b_dout), 64'(qb[0].d));
          check("b_rd_cycle", 64'(cyc), 64'(qb[0].c));
          void'(qb.pop_front());
        end
      end
    end
  end

  task automatic req(input logic we_n, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] exp, input int exp_stalls,
                     input string tag);
    int stalls;
    @(negedge clk);
    csb0 = 1'b0; web0 = we_n; addr0 = a; din0 = d; wmask0 = m; cur_exp = exp;
    #1;
    stalls = 0;
    while (!a_ready && stalls < 40) begin
      @(negedge clk); #1;
      stalls++;
    end
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
  endtask

  task automatic idle();
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  64'(a_ready),  64'(0));
    check({tag, "_dvalid"}, 64'(a_dv),     64'(0));
    check({tag, "_dout"},   64'(a_dout),   64'(0));
    check({tag, "_csb"},    64'(a_bcsb),   64'hF);
    check({tag, "_web"},    64'(a_bweb),   64'hF);
    check({tag, "_sleep"},  64'(a_bsleep), 64'(0));
    check({tag, "_bus"},    {a_baddr, a_bdin, a_bwm}, 64'(0));
    check({tag, "_b_dv"},   64'(b_dv),     64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0; wmask0 = '0; cur_exp = '0;
    #1;
    check_reset("rst");
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("ready_after_rst", 64'(a_ready), 64'(1));

    // Write bank 0 and look at the S1 bank drive
    req(1'b0, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0, 0, "w005");
    idle(); #1;
    check("s1_csb",  64'(a_bcsb),  64'(4'b1110));
    check("s1_web",  64'(a_bweb),  64'(4'b1110));
    check("s1_addr", 64'(a_baddr), 64'(8'h05));
    check("s1_din",  64'(a_bdin),  64'(32'hDEADBEEF));

    req(1'b0, 10'h105, 32'h11112222, 4'hF, 32'h0, 0, "w105");
    req(1'b0, 10'h205, 32'h33334444, 4'hF, 32'h0, 0, "w205");
    req(1'b0, 10'h305, 32'h55556666, 4'hF, 32'h0, 0, "w305");
    req(1'b1, 10'h005, 32'h0, 4'h0, 32'hDEADBEEF, 0, "r005");

    // Masked write: lanes 0 and 2 cleared
    req(1'b0, 10'h006, 32'hFFFFFFFF, 4'hF, 32'h0, 0, "w006");
    req(1'b0, 10'h006, 32'h00000000, 4'b0101, 32'h0, 0, "w006m");
    req(1'b1, 10'h006, 32'h0, 4'h0, 32'hFF00FF00, 0, "r006");

    // Top of bank 0 then bottom of bank 1
    req(1'b0, 10'h0FF, 32'hCAFE0001, 4'hF, 32'h0, 0, "w0ff");
    req(1'b0, 10'h100, 32'hBEEF0002, 4'hF, 32'h0, 0, "w100");
    req(1'b1, 10'h0FF, 32'h0, 4'h0, 32'hCAFE0001, 0, "r0ff");
    req(1'b1, 10'h100, 32'h0, 4'h0, 32'hBEEF0002, 0, "r100");

    // Interleaved reads across all banks, no bubbles
    req(1'b1, 10'h005, 32'h0, 4'h0, 32'hDEADBEEF, 0, "il0");
    req(1'b1, 10'h105, 32'h0, 4'h0, 32'h11112222, 0, "il1");
    req(1'b1, 10'h205, 32'h0, 4'h0, 32'h33334444, 0, "il2");
    req(1'b1, 10'h305, 32'h0, 4'h0, 32'h55556666, 0, "il3");

    // Idle timeout: banks sleep 16 cycles after their last S1 access
    idle();
    repeat (16) @(negedge clk);
    #1;
    check("sleep_pre",  64'(a_bsleep), 64'(4'b0111));
    @(negedge clk); #1;
    check("sleep_all",  64'(a_bsleep), 64'(4'b1111));
    check("a_ready_asleep", 64'(a_ready), 64'(0));
    check("b_ready_never_sleeps", 64'(b_ready), 64'(1));
    check("b_sleep_never", 64'(b_bsleep), 64'(0));

    // Wake bank 2: three stall cycles, accepted on the fourth
    req(1'b1, 10'h205, 32'h0, 4'h0, 32'h33334444, 3, "wake2");
    check("wake2_sleep_bit", 64'(a_bsleep[2]), 64'(0));

    // Wake bank 1, then access it exactly on its timeout edge
    req(1'b1, 10'h105, 32'h0, 4'h0, 32'h11112222, 3, "wake1");
    idle();
    repeat (15) @(negedge clk);
    req(1'b1, 10'h105, 32'h0, 4'h0, 32'h11112222, 0, "to1");
    idle(); #1;
    check("to1_stays_awake", 64'(a_bsleep[1]), 64'(0));

    // Reset one cycle after a read is accepted
    req(1'b1, 10'h005, 32'h0, 4'h0, 32'hDEADBEEF, 3, "rstrd");
    @(negedge clk);
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1;
    qa.delete(); qb.delete();
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_ready", 64'(a_ready), 64'(1));
    check("qa_drained", 64'(qa.size()), 64'(0));
    check("qb_drained", 64'(qb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
